// File: rtl/ssd_pkg.sv
// Shared types, constants and helpers for the seven-segment scan controller.
// Segment codes are active-low {g,f,e,d,c,b,a}.
package ssd_pkg;

  typedef enum logic {IDLE = 1'b0, CONV = 1'b1} state_t;

  localparam int unsigned BCD_ITER = 13;

  // Codes 10..15 cannot come out of the converter; they decode to blank.
  localparam logic [6:0] SEG_TAB [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F
  };

  function automatic logic [15:0] dd_adjust(input logic [15:0] bcd);
    logic [15:0] r;
    r = bcd;
    for (int i = 0; i < 4; i++)
      if (r[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
    return r;
  endfunction

endpackage

// File: rtl/ssd_scan_ctrl_if.sv
// Load/display bundle of the scan controller; slave is the controller side.
interface ssd_scan_ctrl_if;
  logic [12:0] value_i;
  logic        load_i;
  logic        busy_o;
  logic [3:0]  anode_o;
  logic [6:0]  seg_o;

  modport master (output value_i, load_i, input busy_o, anode_o, seg_o);
  modport slave  (input value_i, load_i, output busy_o, anode_o, seg_o);
endinterface

// File: rtl/ssd_scan_ctrl_bin2bcd_seq.sv
// Sequential double-dabble converter: one adjust+shift per cycle, 13 cycles.
// bcd/done are valid combinationally on the final conversion cycle.
module bin2bcd_seq
  import ssd_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [12:0] bin,
  output logic        busy,
  output logic [15:0] bcd,
  output logic        done
);

  state_t      state_q;
  logic [12:0] bin_q;
  logic [15:0] bcd_q, bcd_d, adj;
  logic [3:0]  cnt_q;

  assign adj   = dd_adjust(bcd_q);
  assign bcd_d = 16'(adj << 1) | {15'd0, bin_q[12]};
  assign busy  = (state_q == CONV);
  assign done  = busy && (cnt_q == 4'(BCD_ITER - 1));
  assign bcd   = bcd_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          bin_q   <= bin;
          bcd_q   <= '0;
          cnt_q   <= '0;
          state_q <= CONV;
        end
        CONV: begin
          // start is deliberately not looked at here: no queueing
          bcd_q <= bcd_d;
          bin_q <= bin_q << 1;
          cnt_q <= cnt_q + 4'd1;
          if (done) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/ssd_scan_ctrl.sv
// 4-digit multiplexed seven-segment driver with binary-to-BCD load path.
// Optional macro SSD_LEAD_ZERO_BLANK_EN blanks leading zero digits (digit 0 never).
module ssd_scan_ctrl
  import ssd_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic            clk,
  input  logic            rst,
  ssd_scan_ctrl_if.slave  bus
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [CW-1:0] div_q;
  logic [1:0]    idx_q;
  logic [15:0]   disp_q;
  logic [15:0]   bcd;
  logic          done, busy;
  logic [3:0]    dig;
  logic          blank;

  bin2bcd_seq u_conv (
    .clk   (clk),
    .rst   (rst),
    .start (bus.load_i),
    .bin   (bus.value_i),
    .busy  (busy),
    .bcd   (bcd),
    .done  (done)
  );

  assign bus.busy_o = busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q  <= '0;
      idx_q  <= '0;
      disp_q <= '0;
    end else begin
      if (div_q == CW'(REFRESH_DIV - 1)) begin
        div_q <= '0;
        idx_q <= idx_q + 2'd1;
      end else begin
        div_q <= div_q + 1'b1;
      end
      // display only moves on completion, so the old value stays up during CONV
      if (done) disp_q <= bcd;
    end
  end

  assign dig = disp_q[idx_q*4 +: 4];

`ifdef SSD_LEAD_ZERO_BLANK_EN
  always_comb begin
    blank = 1'b0;
    case (idx_q)
      2'd1:    blank = (disp_q[15:4]  == '0);
      2'd2:    blank = (disp_q[15:8]  == '0);
      2'd3:    blank = (disp_q[15:12] == '0);
      default: blank = 1'b0;
    endcase
  end
`else
  assign blank = 1'b0;
`endif

  assign bus.anode_o = ~(4'b0001 << idx_q);
  assign bus.seg_o   = blank ? 7'h7F : SEG_TAB[dig];

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Randomized self-checking bench for ssd_scan_ctrl against a decimal/timing model.
module tb_ssd_scan_ctrl;

  localparam int DIV = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ssd_scan_ctrl_if bus();

  ssd_scan_ctrl #(.REFRESH_DIV(DIV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int ncmp = 0, nfail = 0;

  // Reference model: conversion as a 13-cycle countdown, display as a decimal number.
  int m_rem = 0, m_pend = 0, m_disp = 0, m_ncyc = 0;
  logic [6:0] SEG [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  int P10 [4] = '{1, 10, 100, 1000};

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_rem  <= 0;
      m_disp <= 0;
      m_ncyc <= 0;
    end else begin
      m_ncyc <= m_ncyc + 1;
      if (m_rem == 0) begin
        if (bus.load_i) begin
          m_rem  <= 13;
          m_pend <= int'(bus.value_i);
        end
      end else begin
        m_rem <= m_rem - 1;
        if (m_rem == 1) m_disp <= m_pend;
      end
    end
  end

  function automatic logic [11:0] exp_out();
    int idx;
    int d;
    logic [6:0] s;
    idx = (m_ncyc / DIV) % 4;
    d   = (m_disp / P10[idx]) % 10;
    s   = SEG[d];
`ifdef SSD_LEAD_ZERO_BLANK_EN
    if (idx > 0 && m_disp < P10[idx]) s = 7'h7F;
`endif
    return {(m_rem != 0), ~(4'b0001 << idx), s};
  endfunction

  logic [11:0] act, exp;

  task automatic test_reset();
    rst = 1'b1; bus.load_i = 1'b0; bus.value_i = '0;
    repeat (3) @(negedge clk);
    act = {bus.busy_o, bus.anode_o, bus.seg_o};
    ncmp++;
    if (act !== 12'b0_1110_1000000) begin
      nfail++; $display("FAIL reset_state got=%h exp=%h", act, 12'b0_1110_1000000);
    end
    rst = 1'b0;
    repeat (24) begin
      @(negedge clk);
      act = {bus.busy_o, bus.anode_o, bus.seg_o}; exp = exp_out(); ncmp++;
      if (act !== exp) begin nfail++; $display("FAIL idle_scan cyc=%0d got=%h exp=%h", m_ncyc, act, exp); end
    end
  endtask

  task automatic test_max();
    int bc = 0;
    @(negedge clk); bus.value_i = 13'd8191; bus.load_i = 1'b1;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (i == 0) bus.load_i = 1'b0;
      if (bus.busy_o === 1'b1) bc++;
      act = {bus.busy_o, bus.anode_o, bus.seg_o}; exp = exp_out(); ncmp++;
      if (act !== exp) begin nfail++; $display("FAIL max_8191 cyc=%0d got=%h exp=%h", m_ncyc, act, exp); end
    end
    ncmp++;
    if (bc != 13) begin nfail++; $display("FAIL busy_len got=%0d exp=13", bc); end
  endtask

  task automatic test_ignore();
    @(negedge clk); bus.value_i = 13'd1234; bus.load_i = 1'b1;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      act = {bus.busy_o, bus.anode_o, bus.seg_o}; exp = exp_out(); ncmp++;
      if (act !== exp) begin nfail++; $display("FAIL ignore_load cyc=%0d got=%h exp=%h", m_ncyc, act, exp); end
      // negedge after CONV edge k feeds edge k+1: hits CONV cycles 5 and 13
      bus.load_i  = (k == 4 || k == 12);
      bus.value_i = bus.load_i ? 13'd42 : 13'd1234;
    end
    bus.load_i = 1'b0;
  endtask

  task automatic test_reset_mid();
    @(negedge clk); bus.value_i = 13'd7; bus.load_i = 1'b1;
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk);
      if (k == 0) bus.load_i = 1'b0;
      act = {bus.busy_o, bus.anode_o, bus.seg_o}; exp = exp_out(); ncmp++;
      if (act !== exp) begin nfail++; $display("FAIL pre_abort cyc=%0d got=%h exp=%h", m_ncyc, act, exp); end
    end
    rst = 1'b1;
    #1;
    act = {bus.busy_o, bus.anode_o, bus.seg_o}; ncmp++;
    if (act !== 12'b0_1110_1000000) begin
      nfail++; $display("FAIL abort_reset got=%h exp=%h", act, 12'b0_1110_1000000);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (24) begin
      @(negedge clk);
      act = {bus.busy_o, bus.anode_o, bus.seg_o}; exp = exp_out(); ncmp++;
      if (act !== exp) begin nfail++; $display("FAIL post_abort cyc=%0d got=%h exp=%h", m_ncyc, act, exp); end
    end
  endtask

  task automatic test_back_to_back();
    logic second = 1'b0;
    logic prev_busy = 1'b0;
    @(negedge clk); bus.value_i = 13'd5000; bus.load_i = 1'b1;
    for (int i = 0; i < 48; i++) begin
      @(negedge clk);
      act = {bus.busy_o, bus.anode_o, bus.seg_o}; exp = exp_out(); ncmp++;
      if (act !== exp) begin nfail++; $display("FAIL back_to_back cyc=%0d got=%h exp=%h", m_ncyc, act, exp); end
      if (!second && prev_busy && !bus.busy_o) begin
        bus.load_i = 1'b1; bus.value_i = 13'd4999; second = 1'b1;
      end else begin
        bus.load_i = 1'b0;
      end
      prev_busy = bus.busy_o;
    end
    ncmp++;
    if (!second) begin nfail++; $display("FAIL b2b_busy_fall got=none exp=fall"); end
  endtask

  task automatic test_lead_zero();
    @(negedge clk); bus.value_i = 13'd305; bus.load_i = 1'b1;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (i == 0) bus.load_i = 1'b0;
      act = {bus.busy_o, bus.anode_o, bus.seg_o}; exp = exp_out(); ncmp++;
      if (act !== exp) begin nfail++; $display("FAIL lead_zero_305 cyc=%0d got=%h exp=%h", m_ncyc, act, exp); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      act = {bus.busy_o, bus.anode_o, bus.seg_o}; exp = exp_out(); ncmp++;
      if (act !== exp) begin nfail++; $display("FAIL random cyc=%0d got=%h exp=%h", m_ncyc, act, exp); end
      bus.load_i  = ($urandom_range(0, 5) == 0);
      bus.value_i = 13'($urandom_range(0, 8191));
    end
    bus.load_i = 1'b0;
    repeat (20) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_max();
    test_ignore();
    test_reset_mid();
    test_back_to_back();
    test_lead_zero();
    test_random();
    test_lead_zero();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/ssd_scan_ctrl.md
SSD_SCAN_CTRL -- requirements
Module: ssd_scan_ctrl

Interface
REQ-001 Parameter REFRESH_DIV, default 100000, meaning clk cycles per digit slot, legal range 2..2^20.
REQ-002 clk  input  1  system clock, all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 value_i  input  13  unsigned binary value to display, range 0..8191.
REQ-005 load_i  input  1  request to convert and display value_i.
REQ-006 busy_o  output  1  high while a conversion is in progress.
REQ-007 anode_o  output  4  digit enables, active-low one-hot, bit 0 = least significant digit.
REQ-008 seg_o  output  7  segments {g,f,e,d,c,b,a}, active-low.

Function
REQ-009 FSM SHALL have two states: IDLE and CONV.
REQ-010 In IDLE, on a rising edge with load_i=1, the block SHALL capture value_i, clear the BCD shift register, zero the iteration counter and enter CONV.
REQ-011 Each CONV cycle SHALL perform one double-dabble step: add 3 to every BCD nibble >= 5, then shift {bcd,bin} left by one.
REQ-012 After exactly 13 CONV cycles, the block SHALL write the 4 BCD digits into the display registers and return to IDLE on the same edge.
REQ-013 busy_o SHALL equal (state==CONV); it is high for exactly 13 cycles per load.
REQ-014 load_i asserted while in CONV, including on the final CONV edge, SHALL be ignored with no queueing.
REQ-015 Display registers SHALL change only at conversion completion, so the old value stays displayed during CONV.
REQ-016 The refresh counter SHALL count 0..REFRESH_DIV-1 and wrap; at terminal count the digit index SHALL advance 0->1->2->3->0.
REQ-017 anode_o SHALL be ~(4'b0001 << index).
REQ-018 seg_o SHALL be the 7-segment code of the indexed display digit; nibble values 10..15 are unreachable, and the decoder SHALL map them to blank (7'h7F).
REQ-019 The scan SHALL run continuously and independently of the FSM state.

Reset
REQ-020 While rst is high, the block SHALL set: state=IDLE, busy_o=0, counters=0, digit index=0, display digits=0, anode_o=4'b1110, seg_o=7'b1000000 ('0').
REQ-021 Reset during CONV SHALL abort the conversion with no partial display update.

Configuration
REQ-022 Macro SSD_LEAD_ZERO_BLANK_EN: when defined, digits above the most significant nonzero digit SHALL drive seg_o=7'h7F.
REQ-023 Digit 0 SHALL never be blanked, so value 0 shows '0'.
REQ-024 When the macro is undefined, all four digits SHALL be shown, including leading zeros.

Structure
REQ-025 Shared package ssd_pkg SHALL hold the FSM state typedef, the BCD iteration count constant (13) and the 16-entry segment code table.
REQ-026 Conversion SHALL live in sub-module bin2bcd_seq (ports clk, rst, start, bin, busy, bcd[15:0], done).
REQ-027 Scan and segment decode SHALL remain in ssd_scan_ctrl.

Verification (REFRESH_DIV=4 in bench)
REQ-028 Reset release, no load -> anode_o cycles 1110,1101,1011,0111 every 4 clks; seg_o=1000000 in every slot with the macro undefined.
REQ-029 load_i=1 for 1 cycle with value_i=8191 -> busy_o high for exactly 13 cycles; slots then show 8,1,9,1 (digit3..0).
REQ-030 Load 1234, then assert load_i with value_i=42 on CONV cycles 5 and 13 -> both ignored; display 1,2,3,4.
REQ-031 Load 7, then raise rst on CONV cycle 6 -> busy_o=0 and digits 0 immediately; after release the display shows 0000.
REQ-032 With SSD_LEAD_ZERO_BLANK_EN defined, load 305 -> digit3 seg_o=1111111; digits 2..0 show 3,0,5 (internal zero kept).
REQ-033 Load 9999-equivalent boundary 5000 back-to-back with 4999 (second load one cycle after busy_o falls) -> display 5000 then 4999, with no intermediate glitch value.
